// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed Q(W-F).F divider, dout = (din1 << FRAC_BITS) / din2, saturated
//   clk, rst (async, active-high)
//   in_valid/in_ready + din1, din2 : operand handshake (accepted only when idle)
//   out_valid/out_ready + dout     : result handshake, held until accepted
//   div_by_zero, overflow          : qualify dout
module fixed_point_divider #(
  parameter int DATA_WIDTH = 19,
  parameter int FRAC_BITS  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  div_by_zero,
  output logic                  overflow
);
  localparam int W    = DATA_WIDTH;
  localparam int ITER = DATA_WIDTH + FRAC_BITS;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state;
  logic            sign;
  logic [W-1:0]    dvs;
  logic [ITER-1:0] dvd;
  logic [W:0]      rem;
  logic [ITER-1:0] quo;
  logic [CW-1:0]   count;
  logic [W-1:0]    mag1, mag2, q_w, dout_nx, dz_dout;
  logic [W:0]      rem_sh, rem_nx;
  logic [ITER-1:0] quo_nx, lim;
  logic            ge, ovf_nx;
  always_comb begin
    mag1    = din1[W-1] ? -din1 : din1;
    mag2    = din2[W-1] ? -din2 : din2;
    rem_sh  = {rem[W-1:0], dvd[ITER-1]};
    ge      = rem_sh >= {1'b0, dvs};
    rem_nx  = ge ? rem_sh - {1'b0, dvs} : rem_sh;
    quo_nx  = {quo[ITER-2:0], ge};
    // negative results may reach 2^(W-1) in magnitude, positive ones only 2^(W-1)-1
    lim     = sign ? {{(ITER-W){1'b0}}, 1'b1, {(W-1){1'b0}}} : {{(ITER-W+1){1'b0}}, {(W-1){1'b1}}};
    ovf_nx  = quo_nx > lim;
    q_w     = quo_nx[W-1:0];
    dout_nx = ovf_nx ? (sign ? MIN : MAX) : (sign ? -q_w : q_w);
    dz_dout = (din1 == '0) ? '0 : (din1[W-1] ? MIN : MAX);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      dout        <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      sign        <= 1'b0;
      dvs         <= '0;
      dvd         <= '0;
      rem         <= '0;
      quo         <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign     <= din1[W-1] ^ din2[W-1];
          dvs      <= mag2;
          dvd      <= {mag1, {FRAC_BITS{1'b0}}};
          rem      <= '0;
          quo      <= '0;
          count    <= CW'(ITER);
          in_ready <= 1'b0;
          overflow <= 1'b0;
          if (din2 == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b1;
            dout        <= dz_dout;
          end else begin
            state       <= CALC;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          rem   <= rem_nx;
          quo   <= quo_nx;
          dvd   <= dvd << 1;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            dout      <= dout_nx;
            overflow  <= ovf_nx;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
